// File: rtl/bus_pkg.sv
// Shared types and widths for the two-master bus arbiter.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // IDLE: nobody owns the device port. OWNk: master k owns it until completion or timeout.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // One-hot owner view of the arbiter state; 00 when idle.
  function automatic logic [1:0] owner_onehot(input arb_state_t s);
    owner_onehot = {s == OWN1, s == OWN0};
  endfunction

endpackage

// File: rtl/rr_pick_2.sv
// Combinational tie-break between two requesters.
// last = 1 means h1 won most recently, so h0 is favoured on the next tie.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] pick
);

  // A lone requester always wins; a tie goes to h0 under fixed priority, else away from last.
  always_comb begin
    pick = 2'b00;
    if (req == 2'b01) begin
      pick = 2'b01;
    end else if (req == 2'b10) begin
      pick = 2'b10;
    end else if (req == 2'b11) begin
      pick = (fixed || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bus_arbiter_2.sv
// Two-master arbiter in front of a single device port, with per-transaction
// ownership, round-robin or fixed-priority tie-break, and a watchdog.
//
// Handshake: a master raises hN_wen or hN_ren (wen wins if both) and holds its
// request and payload until hN_ready pulses for one cycle; hN_rdata is valid only
// in that cycle. While a master owns the port, dev_* follow it combinationally and
// dev_ready is the completion pulse. The owner returns to IDLE for at least one
// cycle between transactions.
module bus_arbiter_2
  import bus_pkg::*;
#(
  parameter bit                FIXED_PRIORITY = 1'b0,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [BUS_DW-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BUS_AW-1:0] h0_addr,
  input  logic [BUS_DW-1:0] h0_wdata,
  input  logic [3:0]        h0_wmask,
  input  logic              h0_wen,
  input  logic              h0_ren,
  output logic [BUS_DW-1:0] h0_rdata,
  output logic              h0_ready,
  input  logic [BUS_AW-1:0] h1_addr,
  input  logic [BUS_DW-1:0] h1_wdata,
  input  logic [3:0]        h1_wmask,
  input  logic              h1_wen,
  input  logic              h1_ren,
  output logic [BUS_DW-1:0] h1_rdata,
  output logic              h1_ready,
  output logic [BUS_AW-1:0] dev_addr,
  output logic [BUS_DW-1:0] dev_wdata,
  output logic [3:0]        dev_wmask,
  output logic              dev_wen,
  output logic              dev_ren,
  input  logic [BUS_DW-1:0] dev_rdata,
  input  logic              dev_ready,
  output logic [1:0]        grant,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  logic [1:0]    req;
  logic [1:0]    pick;
  logic          busy;
  logic          sel1;
  logic          expire;
  logic          m_wen;
  logic          m_ren;
  logic [BUS_DW-1:0] owner_rdata;
  logic          owner_ready;

  assign req  = {h1_wen | h1_ren, h0_wen | h0_ren};
  assign busy = (state_q != IDLE);
  assign sel1 = (state_q == OWN1);

  // Expiry only fires when the device has not answered in the same cycle.
  assign expire = WD_EN && busy && (cnt_q == CNT_LAST) && !dev_ready;

  rr_pick_2 u_pick (
    .req  (req),
    .last (last_q),
    .fixed(FIXED_PRIORITY),
    .pick (pick)
  );

  // State, last-winner pointer, watchdog counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state: grant from IDLE, release to IDLE on completion or expiry.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick[0]) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (pick[1]) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (dev_ready || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output muxes: owner drives the device port, device response goes back to the owner only.
  always_comb begin
    dev_addr    = '0;
    dev_wdata   = '0;
    dev_wmask   = '0;
    dev_wen     = 1'b0;
    dev_ren     = 1'b0;
    h0_rdata    = '0;
    h0_ready    = 1'b0;
    h1_rdata    = '0;
    h1_ready    = 1'b0;
    m_wen       = 1'b0;
    m_ren       = 1'b0;
    owner_rdata = '0;
    owner_ready = 1'b0;
    if (busy) begin
      dev_addr    = sel1 ? h1_addr  : h0_addr;
      dev_wdata   = sel1 ? h1_wdata : h0_wdata;
      dev_wmask   = sel1 ? h1_wmask : h0_wmask;
      m_wen       = sel1 ? h1_wen   : h0_wen;
      m_ren       = sel1 ? h1_ren   : h0_ren;
      dev_wen     = m_wen & ~expire;
      dev_ren     = m_ren & ~m_wen & ~expire;
      owner_rdata = expire ? ERR_RDATA : dev_rdata;
      owner_ready = dev_ready | expire;
      if (sel1) begin
        h1_rdata = owner_rdata;
        h1_ready = owner_ready;
      end else begin
        h0_rdata = owner_rdata;
        h0_ready = owner_ready;
      end
    end
  end

  assign grant       = owner_onehot(state_q);
  assign timeout_err = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Bench for bus_arbiter_2: two instances (round-robin with an 8-cycle watchdog,
// fixed priority with the watchdog disabled) share the same master and device
// stimulus and are compared every cycle against a transaction-level model.
module tb_bus_arbiter_2;
  import bus_pkg::*;

  localparam logic [31:0] ERR   = 32'hDEADBEEF;
  localparam int          TO_RR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus and observed signals ----------------
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [3:0]  wmask[2];
  logic        wen  [2];
  logic        ren  [2];
  logic [31:0] dev_rdata;
  logic        dev_ready;

  logic [31:0] h_rdata[2][2];
  logic        h_ready[2][2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata[2];
  logic [3:0]  d_wmask[2];
  logic        d_wen  [2];
  logic        d_ren  [2];
  logic [1:0]  gnt    [2];
  logic [1:0]  sdbg   [2];
  logic        terr   [2];

  // ---------------- model state ----------------
  int   to_c [2];
  bit   fp_c [2];
  int   m_own[2];
  logic m_last[2];
  int   m_age[2];
  logic m_err[2];
  logic m_exp[2];

  logic [31:0] exp_q[$];
  int          served_rr[$];
  int          fp_h1_grants;
  logic        seen_rdy[2];
  int          tests  = 0;
  int          failed = 0;

  bus_arbiter_2 #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO_RR), .ERR_RDATA(ERR)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .h0_addr(addr[0]), .h0_wdata(wdata[0]), .h0_wmask(wmask[0]), .h0_wen(wen[0]), .h0_ren(ren[0]),
    .h0_rdata(h_rdata[0][0]), .h0_ready(h_ready[0][0]),
    .h1_addr(addr[1]), .h1_wdata(wdata[1]), .h1_wmask(wmask[1]), .h1_wen(wen[1]), .h1_ren(ren[1]),
    .h1_rdata(h_rdata[0][1]), .h1_ready(h_ready[0][1]),
    .dev_addr(d_addr[0]), .dev_wdata(d_wdata[0]), .dev_wmask(d_wmask[0]),
    .dev_wen(d_wen[0]), .dev_ren(d_ren[0]), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .grant(gnt[0]), .timeout_err(terr[0]), .state_dbg(sdbg[0])
  );

  bus_arbiter_2 #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(0), .ERR_RDATA(ERR)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .h0_addr(addr[0]), .h0_wdata(wdata[0]), .h0_wmask(wmask[0]), .h0_wen(wen[0]), .h0_ren(ren[0]),
    .h0_rdata(h_rdata[1][0]), .h0_ready(h_ready[1][0]),
    .h1_addr(addr[1]), .h1_wdata(wdata[1]), .h1_wmask(wmask[1]), .h1_wen(wen[1]), .h1_ren(ren[1]),
    .h1_rdata(h_rdata[1][1]), .h1_ready(h_ready[1][1]),
    .dev_addr(d_addr[1]), .dev_wdata(d_wdata[1]), .dev_wmask(d_wmask[1]),
    .dev_wen(d_wen[1]), .dev_ren(d_ren[1]), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .grant(gnt[1]), .timeout_err(terr[1]), .state_dbg(sdbg[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_last[d] = 1'b1;
      m_age[d]  = 0;
      m_err[d]  = 1'b0;
      m_exp[d]  = 1'b0;
    end
  endtask

  // Expected outputs follow from who owns the port and how long they have held it.
  task automatic check_outputs();
    int          k;
    logic        expire;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_wen, e_ren;
    logic [1:0]  e_gnt;
    logic        e_rdy[2];
    logic [31:0] e_rd[2];
    string       p;
    for (int d = 0; d < 2; d++) begin
      p = $sformatf("d%0d", d);
      k = m_own[d];
      expire = 1'b0;
      e_addr = '0; e_wdata = '0; e_wmask = '0; e_wen = 1'b0; e_ren = 1'b0; e_gnt = 2'b00;
      e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      if (rst_n && k >= 0) begin
        expire  = (to_c[d] != 0) && (m_age[d] == to_c[d] - 1) && !dev_ready;
        e_addr  = addr[k];
        e_wdata = wdata[k];
        e_wmask = wmask[k];
        e_wen   = wen[k] && !expire;
        e_ren   = ren[k] && !wen[k] && !expire;
        e_rdy[k] = dev_ready || expire;
        e_rd[k]  = expire ? ERR : dev_rdata;
        e_gnt    = (k == 0) ? 2'b01 : 2'b10;
      end
      m_exp[d] = expire;
      check({p, " grant"},      32'(gnt[d]),            32'(e_gnt));
      check({p, " state_idle"}, 32'(sdbg[d] == IDLE),   32'(k < 0));
      check({p, " dev_addr"},   d_addr[d],              e_addr);
      check({p, " dev_wdata"},  d_wdata[d],             e_wdata);
      check({p, " dev_wmask"},  32'(d_wmask[d]),        32'(e_wmask));
      check({p, " dev_wen"},    32'(d_wen[d]),          32'(e_wen));
      check({p, " dev_ren"},    32'(d_ren[d]),          32'(e_ren));
      check({p, " timeout_err"}, 32'(terr[d]),          32'(m_err[d]));
      for (int m = 0; m < 2; m++) begin
        check($sformatf("%s h%0d_ready", p, m), 32'(h_ready[d][m]), 32'(e_rdy[m]));
        check($sformatf("%s h%0d_rdata", p, m), h_rdata[d][m], e_rd[m]);
        if (e_rdy[m]) exp_q.push_back(e_rd[m]);
        if (h_ready[d][m]) begin
          check({p, " sb_pending"}, exp_q.size(), 1);
          if (exp_q.size() != 0) check({p, " sb_rdata"}, h_rdata[d][m], exp_q.pop_front());
          if (d == 0) served_rr.push_back(m);
        end
        check({p, " sb_drain"}, exp_q.size(), 0);
        exp_q.delete();
      end
      if (d == 1 && gnt[1] == 2'b10) fp_h1_grants++;
    end
  endtask

  // Transaction-level rules: grant from idle, one transaction per ownership, no direct hop.
  task automatic advance_model();
    logic r0, r1;
    int   w;
    r0 = wen[0] | ren[0];
    r1 = wen[1] | ren[1];
    for (int d = 0; d < 2; d++) begin
      if (m_own[d] < 0) begin
        if (r0 || r1) begin
          if (r0 && r1) w = fp_c[d] ? 0 : int'(!m_last[d]);
          else          w = r0 ? 0 : 1;
          m_own[d]  = w;
          m_last[d] = (w == 1);
          m_age[d]  = 0;
        end
      end else if (dev_ready || m_exp[d]) begin
        if (m_exp[d]) m_err[d] = 1'b1;
        m_own[d] = -1;
      end else begin
        m_age[d]++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    seen_rdy[0] = h_ready[0][0];
    seen_rdy[1] = h_ready[0][1];
    if (rst_n) advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int m = 0; m < 2; m++) begin
      wen[m] = 1'b0;
      ren[m] = 1'b0;
    end
  endtask

  task automatic drain();
    clear_reqs();
    dev_ready = 1'b1;
    repeat (3) step();
    dev_ready = 1'b0;
  endtask

  task automatic new_req(input int m);
    int kind;
    kind     = $urandom_range(0, 2);
    addr[m]  = $urandom;
    wdata[m] = $urandom;
    wmask[m] = 4'($urandom_range(0, 15));
    wen[m]   = (kind != 0);
    ren[m]   = (kind != 1);
  endtask

  task automatic rand_masters();
    for (int m = 0; m < 2; m++) begin
      if ((wen[m] || ren[m]) && seen_rdy[m]) begin
        if ($urandom_range(0, 3) == 0) new_req(m);
        else begin wen[m] = 1'b0; ren[m] = 1'b0; end
      end else if (!(wen[m] || ren[m])) begin
        if ($urandom_range(0, 2) == 0) new_req(m);
      end else if ($urandom_range(0, 60) == 0) begin
        wen[m] = 1'b0;
        ren[m] = 1'b0;
      end
    end
    dev_ready = ($urandom_range(0, 3) == 0);
    dev_rdata = $urandom;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    to_c[0] = TO_RR; to_c[1] = 0;
    fp_c[0] = 1'b0;  fp_c[1] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wdata[m] = '0; wmask[m] = '0; seen_rdy[m] = 1'b0;
    end
    clear_reqs();
    dev_ready = 1'b0;
    dev_rdata = '0;
    fp_h1_grants = 0;
    model_reset();

    // Reset state.
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tie from reset: round-robin alternates, fixed priority never grants h1.
    served_rr.delete();
    fp_h1_grants = 0;
    addr[0] = 32'hF000_0020; addr[1] = 32'hF000_0030;
    ren[0] = 1'b1; ren[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dev_ready = (i % 2 == 1);
      dev_rdata = 32'h1000_0000 + 32'(i);
      step();
    end
    check("tie_count", 32'(served_rr.size() >= 4), 1);
    for (int j = 0; j < 4; j++) begin
      if (j < served_rr.size()) check($sformatf("tie_order%0d", j), 32'(served_rr[j]), 32'(j % 2));
    end
    check("fp_h1_never", 32'(fp_h1_grants), 0);
    drain();

    // Single master read with a three-cycle device.
    addr[0] = 32'hF000_0010;
    ren[0]  = 1'b1;
    step();
    check("rd_grant", 32'(gnt[0]), 32'(2'b01));
    step();
    step();
    dev_ready = 1'b1;
    dev_rdata = 32'h1234_5678;
    #1;
    check("rd_ready", 32'(h_ready[0][0]), 1);
    check("rd_rdata", h_rdata[0][0], 32'h1234_5678);
    check("rd_other", 32'(h_ready[0][1]), 0);
    step();
    ren[0] = 1'b0;
    dev_ready = 1'b0;
    check("rd_release", 32'(gnt[0]), 0);
    drain();

    // Write passthrough from h1 with idle h0 carrying different values.
    addr[0] = 32'h1111_2222; wdata[0] = 32'h3333_4444; wmask[0] = 4'hF;
    addr[1] = 32'hF000_0004; wdata[1] = 32'hA5A5_A5A5; wmask[1] = 4'b0011;
    wen[1] = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      check("wr_grant", 32'(gnt[0]), 32'(2'b10));
      check("wr_addr",  d_addr[0], 32'hF000_0004);
      check("wr_wdata", d_wdata[0], 32'hA5A5_A5A5);
      check("wr_wmask", 32'(d_wmask[0]), 32'(4'b0011));
      check("wr_wen",   32'(d_wen[0]), 1);
      check("wr_ren",   32'(d_ren[0]), 0);
      step();
    end
    dev_ready = 1'b1;
    #1;
    check("wr_ready", 32'(h_ready[0][1]), 1);
    step();
    drain();

    // Watchdog: silent device, h0 gets the error word in its 8th owned cycle.
    addr[0] = 32'hF000_0100;
    ren[0]  = 1'b1;
    step();
    for (int i = 1; i < TO_RR; i++) begin
      check("to_wait", 32'(h_ready[0][0]), 0);
      step();
    end
    check("to_ready", 32'(h_ready[0][0]), 1);
    check("to_rdata", h_rdata[0][0], ERR);
    check("to_ren_forced", 32'(d_ren[0]), 0);
    step();
    ren[0] = 1'b0;
    check("to_err_set", 32'(terr[0]), 1);
    addr[1] = 32'hF000_0200;
    ren[1]  = 1'b1;
    step();
    check("to_next_grant", 32'(gnt[0]), 32'(2'b10));
    dev_ready = 1'b1;
    dev_rdata = 32'h0BAD_F00D;
    #1;
    check("to_next_ready", 32'(h_ready[0][1]), 1);
    check("to_next_rdata", h_rdata[0][1], 32'h0BAD_F00D);
    step();
    ren[1] = 1'b0;
    dev_ready = 1'b0;
    step();
    check("to_err_sticky", 32'(terr[0]), 1);
    drain();

    // Reset in the second cycle of an h1 write.
    addr[1] = 32'hF000_0008; wdata[1] = 32'h5A5A_5A5A; wmask[1] = 4'hF;
    wen[1] = 1'b1;
    step();
    step();
    check("rst_pre_wen", 32'(d_wen[0]), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wen", 32'(d_wen[0]), 0);
    check("rst_grant", 32'(gnt[0]), 0);
    check_outputs();
    ren[0] = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("rst_after_grant", 32'(gnt[0]), 32'(2'b01));
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_masters();
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
